// File: rtl/traffic_light_ctrl_if.sv
// Traffic light controller state codes, lamp patterns and I/O bundle.
// slave: Tick_in/Ped_req in; NS_light/EW_light/Walk/Ped_ack/State out.
package traffic_light_ctrl_pkg;
  typedef enum logic [2:0] {
    RED_A     = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    RED_B     = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6
  } state_e;

  localparam logic [2:0] LT_R = 3'b100;
  localparam logic [2:0] LT_Y = 3'b010;
  localparam logic [2:0] LT_G = 3'b001;
endpackage

interface traffic_light_ctrl_if;
  logic       Tick_in;
  logic       Ped_req;
  logic [2:0] NS_light;
  logic [2:0] EW_light;
  logic       Walk;
  logic       Ped_ack;
  logic [2:0] State;

  modport master (
    output Tick_in, Ped_req,
    input  NS_light, EW_light, Walk, Ped_ack, State
  );

  modport slave (
    input  Tick_in, Ped_req,
    output NS_light, EW_light, Walk, Ped_ack, State
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-way traffic light FSM paced by a synchronised slow tick, with walk phase.
// Ports: Clk, nReset (async low), io (slave: tick/request in, lamps/status out).
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int unsigned TW           = 8,
  parameter int unsigned GREEN_TICKS  = 10,
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned WALK_TICKS   = 6
) (
  input logic              Clk,
  input logic              nReset,
  traffic_light_ctrl_if.slave io
);

  localparam int unsigned G_D = (GREEN_TICKS  < 1) ? 1 : GREEN_TICKS;
  localparam int unsigned Y_D = (YELLOW_TICKS < 1) ? 1 : YELLOW_TICKS;
  localparam int unsigned R_D = (ALLRED_TICKS < 1) ? 1 : ALLRED_TICKS;
  localparam int unsigned W_D = (WALK_TICKS   < 1) ? 1 : WALK_TICKS;

  localparam logic [TW-1:0] G_LAST = TW'(G_D - 1);
  localparam logic [TW-1:0] Y_LAST = TW'(Y_D - 1);
  localparam logic [TW-1:0] R_LAST = TW'(R_D - 1);
  localparam logic [TW-1:0] W_LAST = TW'(W_D - 1);

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  logic          tick_s1_q, tick_s1_d;
  logic          tick_s2_q, tick_s2_d;
  logic          tick_prev_q, tick_prev_d;
  logic [1:0]    vld_q, vld_d;
  logic          arm_q, arm_d;
  logic          ped_s1_q, ped_s1_d;
  logic          ped_s2_q, ped_s2_d;
  logic          ped_prev_q, ped_prev_d;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d;
  logic          dir_q, dir_d;
  logic          ack_q, ack_d;
  logic          walk_q, walk_d;
  logic [2:0]    ns_q, ns_d;
  logic [2:0]    ew_q, ew_d;

  logic          tick;
  logic          ped_edge;
  logic          expire;
  logic          enter_walk;
  logic [TW-1:0] last;

  always_comb begin
    tick_s1_d   = io.Tick_in;
    tick_s2_d   = tick_s1_q;
    tick_prev_d = tick_s2_q;
    ped_s1_d    = io.Ped_req;
    ped_s2_d    = ped_s1_q;
    ped_prev_d  = ped_s2_q;

    // Ticks are armed only once the synchronised input has been seen
    // low, so a Tick_in already high at reset release is not an edge.
    vld_d = {vld_q[0], 1'b1};
    arm_d = arm_q | (vld_q[1] & ~tick_s2_q);

    tick     = arm_q & tick_s2_q & ~tick_prev_q;
    ped_edge = ped_s2_q & ~ped_prev_q;

    unique case (state_q)
      NS_GREEN, EW_GREEN:   last = G_LAST;
      NS_YELLOW, EW_YELLOW: last = Y_LAST;
      RED_A, RED_B:         last = R_LAST;
      PED_WALK:             last = W_LAST;
      default:              last = '0;
    endcase

    expire  = tick & (timer_q == last);
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = tick ? timer_q + TW'(1) : timer_q;
    pend_d  = pend_q | (ped_edge & (state_q != PED_WALK));

    unique case (state_q)
      RED_A: if (expire) begin
        state_d = pend_q ? PED_WALK : NS_GREEN;
        dir_d   = pend_q ? DIR_NS : dir_q;
      end
      NS_GREEN:  if (expire) state_d = NS_YELLOW;
      NS_YELLOW: if (expire) state_d = RED_B;
      RED_B: if (expire) begin
        state_d = pend_q ? PED_WALK : EW_GREEN;
        dir_d   = pend_q ? DIR_EW : dir_q;
      end
      EW_GREEN:  if (expire) state_d = EW_YELLOW;
      EW_YELLOW: if (expire) state_d = RED_A;
      PED_WALK: if (expire) begin
        state_d = (dir_q == DIR_EW) ? EW_GREEN : NS_GREEN;
      end
      default: begin
        state_d = RED_A;
        timer_d = '0;
      end
    endcase

    if (expire) timer_d = '0;

    // An edge landing on the entry cycle is absorbed by this clear.
    enter_walk = (state_d == PED_WALK) & (state_q != PED_WALK);
    if (enter_walk) pend_d = 1'b0;

    ack_d  = enter_walk;
    walk_d = (state_d == PED_WALK);
    ns_d   = LT_R;
    ew_d   = LT_R;
    unique case (1'b1)
      state_d == NS_GREEN:  ns_d = LT_G;
      state_d == NS_YELLOW: ns_d = LT_Y;
      state_d == EW_GREEN:  ew_d = LT_G;
      state_d == EW_YELLOW: ew_d = LT_Y;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      tick_s1_q   <= 1'b0;
      tick_s2_q   <= 1'b0;
      tick_prev_q <= 1'b0;
      vld_q       <= 2'b00;
      arm_q       <= 1'b0;
      ped_s1_q    <= 1'b0;
      ped_s2_q    <= 1'b0;
      ped_prev_q  <= 1'b0;
      state_q     <= RED_A;
      timer_q     <= '0;
      pend_q      <= 1'b0;
      dir_q       <= DIR_NS;
      ack_q       <= 1'b0;
      walk_q      <= 1'b0;
      ns_q        <= LT_R;
      ew_q        <= LT_R;
    end else begin
      tick_s1_q   <= tick_s1_d;
      tick_s2_q   <= tick_s2_d;
      tick_prev_q <= tick_prev_d;
      vld_q       <= vld_d;
      arm_q       <= arm_d;
      ped_s1_q    <= ped_s1_d;
      ped_s2_q    <= ped_s2_d;
      ped_prev_q  <= ped_prev_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      dir_q       <= dir_d;
      ack_q       <= ack_d;
      walk_q      <= walk_d;
      ns_q        <= ns_d;
      ew_q        <= ew_d;
    end
  end

  assign io.NS_light = ns_q;
  assign io.EW_light = ew_q;
  assign io.Walk     = walk_q;
  assign io.Ped_ack  = ack_q;
  assign io.State    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with shortened tick period.
// Tick_in period is 20 Clk; GREEN=3, YELLOW=2, ALLRED=1, WALK=2.
module tb_traffic_light_ctrl;
  logic Clk = 1'b0;
  logic nReset;
  int   compared = 0;
  int   mismatched = 0;
  int   ack_cnt = 0;
  int   ack_bad = 0;
  int   walk_bad = 0;
  int   ov_bad = 0;

  always #5 Clk = ~Clk;

  traffic_light_ctrl_if io();

  traffic_light_ctrl #(
    .TW(8),
    .GREEN_TICKS(3),
    .YELLOW_TICKS(2),
    .ALLRED_TICKS(1),
    .WALK_TICKS(2)
  ) dut (
    .Clk(Clk),
    .nReset(nReset),
    .io(io)
  );

  always @(negedge Clk) begin
    if (io.Ped_ack === 1'b1) begin
      ack_cnt++;
      if (io.State !== 3'd6) ack_bad++;
    end
    if (io.Walk !== (io.State == 3'd6)) walk_bad++;
    if ((io.NS_light[1] | io.NS_light[0]) &&
        (io.EW_light[1] | io.EW_light[0])) ov_bad++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      io.Tick_in = 1'b1;
      wait_clk(10);
      io.Tick_in = 1'b0;
      wait_clk(10);
    end
  endtask

  task automatic ped_pulse();
    io.Ped_req = 1'b1;
    wait_clk(3);
    io.Ped_req = 1'b0;
    wait_clk(3);
  endtask

  task automatic chk_state(input string name, input logic [2:0] want);
    // per-scenario state comparison, used inline by each test
    compared++;
    if (io.State !== want) begin
      mismatched++;
      $display("FAIL %s: State got %0d want %0d", name, io.State, want);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    io.Tick_in = 1'b0;
    io.Ped_req = 1'b0;
    wait_clk(2);
    chk_state("reset_state", 3'd0);
    compared++;
    if (io.NS_light !== 3'b100 || io.EW_light !== 3'b100) begin
      mismatched++;
      $display("FAIL reset_lights: got %b/%b want 100/100",
               io.NS_light, io.EW_light);
    end
    compared++;
    if (io.Walk !== 1'b0 || io.Ped_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_walk_ack: got %b/%b want 0/0",
               io.Walk, io.Ped_ack);
    end
    nReset = 1'b1;
    wait_clk(5);
    chk_state("post_release", 3'd0);
  endtask

  task automatic test_cycle();
    logic [2:0] st [11] = '{1,1,2,2,3,4,4,4,5,5,0};
    logic [2:0] ns [11] = '{3'b001,3'b001,3'b010,3'b010,3'b100,3'b100,
                            3'b100,3'b100,3'b100,3'b100,3'b100};
    logic [2:0] ew [11] = '{3'b100,3'b100,3'b100,3'b100,3'b100,3'b001,
                            3'b001,3'b001,3'b010,3'b010,3'b100};
    io.Tick_in = 1'b1;
    wait_clk(2);
    chk_state("tick_latency_early", 3'd0);
    wait_clk(1);
    chk_state("tick_latency_3clk", 3'd1);
    compared++;
    if (io.NS_light !== 3'b001 || io.EW_light !== 3'b100) begin
      mismatched++;
      $display("FAIL ns_green_lights: got %b/%b want 001/100",
               io.NS_light, io.EW_light);
    end
    wait_clk(7);
    io.Tick_in = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 11; i++) begin
      do_tick(1);
      chk_state($sformatf("cycle_tick%0d", i + 2), st[i]);
      compared++;
      if (io.NS_light !== ns[i] || io.EW_light !== ew[i]) begin
        mismatched++;
        $display("FAIL cycle_lights%0d: got %b/%b want %b/%b",
                 i + 2, io.NS_light, io.EW_light, ns[i], ew[i]);
      end
    end
  endtask

  task automatic test_ped_ns_green();
    int a0 = ack_cnt;
    do_tick(1);
    chk_state("ped_ns_green", 3'd1);
    ped_pulse();
    do_tick(3);
    chk_state("ped_yellow", 3'd2);
    do_tick(2);
    chk_state("ped_red_b", 3'd3);
    do_tick(1);
    chk_state("ped_walk_entry", 3'd6);
    compared++;
    if (io.Walk !== 1'b1 || ack_cnt - a0 !== 1) begin
      mismatched++;
      $display("FAIL ped_walk_ack: walk %b acks %0d want 1/1",
               io.Walk, ack_cnt - a0);
    end
    compared++;
    if (io.NS_light !== 3'b100 || io.EW_light !== 3'b100) begin
      mismatched++;
      $display("FAIL walk_lights: got %b/%b want 100/100",
               io.NS_light, io.EW_light);
    end
    do_tick(1);
    chk_state("ped_walk_hold", 3'd6);
    do_tick(1);
    chk_state("ped_to_ew_green", 3'd4);
    compared++;
    if (io.Walk !== 1'b0) begin
      mismatched++;
      $display("FAIL walk_off: got %b want 0", io.Walk);
    end
    do_tick(3);
    do_tick(2);
    chk_state("ped_back_red_a", 3'd0);
  endtask

  task automatic test_absorb();
    int a0 = ack_cnt;
    ped_pulse();
    io.Tick_in = 1'b1;
    io.Ped_req = 1'b1;
    wait_clk(3);
    chk_state("absorb_walk_entry", 3'd6);
    wait_clk(7);
    io.Tick_in = 1'b0;
    io.Ped_req = 1'b0;
    wait_clk(10);
    do_tick(2);
    chk_state("absorb_walk_to_ns", 3'd1);
    do_tick(3);
    do_tick(2);
    chk_state("absorb_red_b", 3'd3);
    do_tick(1);
    chk_state("absorb_no_rewalk", 3'd4);
    compared++;
    if (ack_cnt - a0 !== 1) begin
      mismatched++;
      $display("FAIL absorb_acks: got %0d want 1", ack_cnt - a0);
    end
  endtask

  task automatic test_multi_req();
    int a0 = ack_cnt;
    ped_pulse();
    ped_pulse();
    ped_pulse();
    do_tick(3);
    do_tick(2);
    chk_state("multi_red_a", 3'd0);
    do_tick(1);
    chk_state("multi_walk", 3'd6);
    do_tick(2);
    chk_state("multi_to_ns", 3'd1);
    do_tick(3);
    do_tick(2);
    do_tick(1);
    chk_state("multi_no_second", 3'd4);
    compared++;
    if (ack_cnt - a0 !== 1) begin
      mismatched++;
      $display("FAIL multi_acks: got %0d want 1", ack_cnt - a0);
    end
  endtask

  task automatic test_reset_mid();
    do_tick(3);
    chk_state("mid_ew_yellow", 3'd5);
    io.Tick_in = 1'b1;
    wait_clk(1);
    nReset = 1'b0;
    #1;
    chk_state("mid_reset_state", 3'd0);
    compared++;
    if (io.NS_light !== 3'b100 || io.EW_light !== 3'b100) begin
      mismatched++;
      $display("FAIL mid_reset_lights: got %b/%b want 100/100",
               io.NS_light, io.EW_light);
    end
    wait_clk(2);
    nReset = 1'b1;
    wait_clk(15);
    chk_state("no_tick_high_release", 3'd0);
    io.Tick_in = 1'b0;
    wait_clk(10);
    do_tick(1);
    chk_state("tick_after_rearm", 3'd1);
  endtask

  task automatic test_illegal();
    force dut.state_q = traffic_light_ctrl_pkg::state_e'(3'd7);
    wait_clk(1);
    chk_state("forced_illegal", 3'd7);
    release dut.state_q;
    wait_clk(1);
    chk_state("illegal_recover", 3'd0);
    compared++;
    if (io.NS_light !== 3'b100 || io.EW_light !== 3'b100) begin
      mismatched++;
      $display("FAIL illegal_lights: got %b/%b want 100/100",
               io.NS_light, io.EW_light);
    end
    do_tick(1);
    chk_state("illegal_then_ns", 3'd1);
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_ped_ns_green();
    test_absorb();
    test_multi_req();
    test_reset_mid();
    test_illegal();
    compared++;
    if (ov_bad !== 0) begin
      mismatched++;
      $display("FAIL conflict_lights: got %0d cycles want 0", ov_bad);
    end
    compared++;
    if (ack_bad !== 0) begin
      mismatched++;
      $display("FAIL ack_not_in_walk: got %0d want 0", ack_bad);
    end
    compared++;
    if (walk_bad !== 0) begin
      mismatched++;
      $display("FAIL walk_vs_state: got %0d want 0", walk_bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
